// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues sram-like fetch requests and
// presents the returned instruction to IF/ID, with branch and flush redirection.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel,
   output logic        stallreq_if
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] inst_buf_q;
   logic        discard_q;
   logic [31:0] next_pc_d;
   logic        aligned;

   // Only bit 0 of the stall vector concerns the fetch stage.
   logic unused_stall;
   assign unused_stall = &{1'b0, stall[5:1]};

   assign aligned   = (pc_q[1:0] == 2'b00);
   assign next_pc_d = branch_flag ? branch_target : pc_q + 32'd4;

   assign inst_req    = (state_q == ST_REQ) & ~rst & aligned;
   assign inst_wr     = 1'b0;
   assign inst_size   = 2'b10;
   assign inst_addr   = pc_q;
   assign if_pc       = pc_q;
   assign if_inst     = (state_q == ST_DONE) ? inst_buf_q : 32'd0;
   assign if_adel     = (state_q == ST_DONE) & ~aligned;
   assign stallreq_if = (state_q != ST_DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         state_q    <= ST_REQ;
         discard_q  <= 1'b0;
         inst_buf_q <= 32'd0;
      end else if (flush) begin
         pc_q <= flush_pc;
         unique case (state_q)
            ST_REQ: begin
               // An accepted address still owes us a response, which must be dropped.
               if (aligned && inst_addr_ok) begin
                  state_q   <= ST_WAIT;
                  discard_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  state_q   <= ST_REQ;
                  discard_q <= 1'b0;
               end else begin
                  discard_q <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_REQ;
            default: state_q <= ST_REQ;
         endcase
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (!aligned) begin
                  inst_buf_q <= 32'd0;
                  state_q    <= ST_DONE;
               end else if (inst_addr_ok) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (inst_data_ok) begin
                  if (discard_q) begin
                     discard_q <= 1'b0;
                     state_q   <= ST_REQ;
                  end else begin
                     inst_buf_q <= inst_rdata;
                     state_q    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (!stall[0]) begin
                  pc_q    <= next_pc_d;
                  state_q <= ST_REQ;
               end
            end
            default: state_q <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch: sequential fetch, address
// back-pressure, branches, flush discard, misaligned fetch and DONE hold.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_adel;
   logic        stallreq_if;

   int pass_cnt  = 0;
   int total_cnt = 0;

   if_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .branch_flag  (branch_flag),
      .branch_target(branch_target),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .if_adel      (if_adel),
      .stallreq_if  (stallreq_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
      $fatal(1);
   end

   // One full REQ -> WAIT -> DONE transaction with a zero-latency bridge.
   // Entered at a negedge with the DUT in REQ; redirect inputs are applied in DONE.
   task automatic fetch_one(input string nm, input logic [31:0] addr, input logic [31:0] data,
                            input logic br, input logic [31:0] tgt,
                            input logic fl, input logic [31:0] fpc);
      total_cnt++;
      if ({inst_req, stallreq_if, inst_addr} !== {1'b1, 1'b1, addr})
         $display("FAIL %s req: req/stallreq/addr got %b/%b/%h need 1/1/%h",
                  nm, inst_req, stallreq_if, inst_addr, addr);
      else pass_cnt++;
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      total_cnt++;
      if ({inst_req, stallreq_if, if_inst} !== {1'b0, 1'b1, 32'd0})
         $display("FAIL %s wait: req/stallreq/inst got %b/%b/%h need 0/1/0",
                  nm, inst_req, stallreq_if, if_inst);
      else pass_cnt++;
      inst_data_ok = 1'b1;
      inst_rdata   = data;
      @(negedge clk);
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      total_cnt++;
      if ({stallreq_if, if_adel, if_inst, if_pc} !== {1'b0, 1'b0, data, addr})
         $display("FAIL %s done: stallreq/adel/inst/pc got %b/%b/%h/%h need 0/0/%h/%h",
                  nm, stallreq_if, if_adel, if_inst, if_pc, data, addr);
      else pass_cnt++;
      branch_flag   = br;
      branch_target = tgt;
      flush         = fl;
      flush_pc      = fpc;
      @(negedge clk);
      branch_flag   = 1'b0;
      branch_target = 32'd0;
      flush         = 1'b0;
      flush_pc      = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 6'd0; flush = 1'b0; flush_pc = 32'd0;
      branch_flag = 1'b0; branch_target = 32'd0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({inst_req, stallreq_if, if_adel, if_inst, inst_addr} !== {1'b0, 1'b1, 1'b0, 32'd0, 32'hBFC0_0000})
         $display("FAIL reset_state: req/stallreq/adel/inst/addr got %b/%b/%b/%h/%h need 0/1/0/0/bfc00000",
                  inst_req, stallreq_if, if_adel, if_inst, inst_addr);
      else pass_cnt++;
      total_cnt++;
      if ({inst_wr, inst_size} !== 3'b010)
         $display("FAIL reset_consts: wr/size got %b/%b need 0/10", inst_wr, inst_size);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++;
      if (inst_req !== 1'b1)
         $display("FAIL reset_release_req: got %b need 1", inst_req);
      else pass_cnt++;
   endtask

   task automatic test_sequential();
      fetch_one("seq0", 32'hBFC0_0000, 32'h1111_0000, 1'b0, 32'd0, 1'b0, 32'd0);
      fetch_one("seq1", 32'hBFC0_0004, 32'h2222_0004, 1'b0, 32'd0, 1'b0, 32'd0);
      fetch_one("seq2", 32'hBFC0_0008, 32'h3333_0008, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_addr_backpressure();
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({inst_req, stallreq_if, inst_addr} !== {1'b1, 1'b1, 32'hBFC0_000C})
            $display("FAIL backpressure_%0d: req/stallreq/addr got %b/%b/%h need 1/1/bfc0000c",
                     i, inst_req, stallreq_if, inst_addr);
         else pass_cnt++;
         @(negedge clk);
      end
      fetch_one("bp_fetch", 32'hBFC0_000C, 32'h4444_000C, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_branch();
      fetch_one("nobr", 32'hBFC0_0010, 32'h5555_0010, 1'b0, 32'd0, 1'b0, 32'd0);
      // Flush out of DONE back to 0x10 so the taken-branch case starts from the same PC.
      fetch_one("fl_done", 32'hBFC0_0014, 32'h6666_0014, 1'b0, 32'd0, 1'b1, 32'hBFC0_0010);
      fetch_one("br_taken", 32'hBFC0_0010, 32'h7777_0010, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
      total_cnt++;
      if (inst_addr !== 32'hBFC0_0100)
         $display("FAIL branch_target_addr: got %h need bfc00100", inst_addr);
      else pass_cnt++;
   endtask

   task automatic test_flush_discard();
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      flush    = 1'b1;
      flush_pc = 32'hBFC0_0380;
      @(negedge clk);
      flush    = 1'b0;
      flush_pc = 32'd0;
      total_cnt++;
      if ({inst_req, stallreq_if, inst_addr} !== {1'b0, 1'b1, 32'hBFC0_0380})
         $display("FAIL flush_wait: req/stallreq/addr got %b/%b/%h need 0/1/bfc00380",
                  inst_req, stallreq_if, inst_addr);
      else pass_cnt++;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      total_cnt++;
      if ({inst_req, stallreq_if, if_inst, inst_addr} !== {1'b1, 1'b1, 32'd0, 32'hBFC0_0380})
         $display("FAIL flush_drop: req/stallreq/inst/addr got %b/%b/%h/%h need 1/1/0/bfc00380",
                  inst_req, stallreq_if, if_inst, inst_addr);
      else pass_cnt++;
      fetch_one("post_flush", 32'hBFC0_0380, 32'h8888_0380, 1'b0, 32'd0, 1'b0, 32'd0);

      // Flush and data_ok in the same WAIT cycle: data dropped, refetch at the flush target.
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      flush        = 1'b1;
      flush_pc     = 32'hBFC0_0200;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hCAFE_F00D;
      @(negedge clk);
      flush        = 1'b0;
      flush_pc     = 32'd0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      total_cnt++;
      if ({inst_req, stallreq_if, if_inst, inst_addr} !== {1'b1, 1'b1, 32'd0, 32'hBFC0_0200})
         $display("FAIL flush_same_cycle: req/stallreq/inst/addr got %b/%b/%h/%h need 1/1/0/bfc00200",
                  inst_req, stallreq_if, if_inst, inst_addr);
      else pass_cnt++;
      fetch_one("post_flush2", 32'hBFC0_0200, 32'h9999_0200, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_misaligned();
      fetch_one("br_mis", 32'hBFC0_0204, 32'hAAAA_0204, 1'b1, 32'hBFC0_0102, 1'b0, 32'd0);
      inst_addr_ok = 1'b1;
      #1;
      total_cnt++;
      if ({inst_req, stallreq_if, inst_addr} !== {1'b0, 1'b1, 32'hBFC0_0102})
         $display("FAIL mis_req: req/stallreq/addr got %b/%b/%h need 0/1/bfc00102",
                  inst_req, stallreq_if, inst_addr);
      else pass_cnt++;
      stall = 6'b000001;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      total_cnt++;
      if ({inst_req, stallreq_if, if_adel, if_inst, if_pc} !== {1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0102})
         $display("FAIL mis_done: req/stallreq/adel/inst/pc got %b/%b/%b/%h/%h need 0/0/1/0/bfc00102",
                  inst_req, stallreq_if, if_adel, if_inst, if_pc);
      else pass_cnt++;
      flush    = 1'b1;
      flush_pc = 32'hBFC0_0380;
      @(negedge clk);
      flush    = 1'b0;
      flush_pc = 32'd0;
      stall    = 6'd0;
      total_cnt++;
      if (if_adel !== 1'b0)
         $display("FAIL mis_flush_adel: got %b need 0", if_adel);
      else pass_cnt++;
      fetch_one("mis_resume", 32'hBFC0_0380, 32'hBBBB_0380, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic test_done_hold();
      inst_addr_ok = 1'b1;
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1;
      inst_rdata   = 32'hA5A5_0001;
      @(negedge clk);
      inst_data_ok = 1'b0;
      inst_rdata   = 32'd0;
      stall        = 6'b000001;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({inst_req, stallreq_if, if_inst, if_pc} !== {1'b0, 1'b0, 32'hA5A5_0001, 32'hBFC0_0384})
            $display("FAIL hold_%0d: req/stallreq/inst/pc got %b/%b/%h/%h need 0/0/a5a50001/bfc00384",
                     i, inst_req, stallreq_if, if_inst, if_pc);
         else pass_cnt++;
         @(negedge clk);
      end
      // Upper stall bits are not the fetch stage's concern.
      stall = 6'b111110;
      @(negedge clk);
      stall = 6'd0;
      total_cnt++;
      if ({inst_req, stallreq_if, inst_addr} !== {1'b1, 1'b1, 32'hBFC0_0388})
         $display("FAIL hold_release: req/stallreq/addr got %b/%b/%h need 1/1/bfc00388",
                  inst_req, stallreq_if, inst_addr);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_addr_backpressure();
      test_branch();
      test_flush_discard();
      test_misaligned();
      test_done_hold();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
